// File: rtl/poker_pkg.sv
// poker_pkg: shared definitions for the card dealing path.
//   - round_e      : round encodings driven by the round sequencer
//   - DECK_SIZE    : cards in the deck (index 0..51)
//   - NUM_SLOTS    : board slots (2 hole, 3 flop, turn, river)
//   - card_t       : {rank, suit} as shown on the display
//   - deal_t       : how many cards a round deals and where they start
//   - deal_lookup  : round -> deal_t
//   - idx_to_card  : deck index -> card_t (rank = idx % 13, suit = idx / 13)
package poker_pkg;

    typedef enum logic [2:0] {
        PREFLOP = 3'd0,
        FLOP    = 3'd1,
        TURN    = 3'd2,
        RIVER   = 3'd3,
        TALLYUP = 3'd4
    } round_e;

    localparam int DECK_SIZE = 52;
    localparam int NUM_SLOTS = 7;
    localparam int NUM_RANKS = 13;

    typedef struct packed {
        logic [3:0] rank;   // 0..12 = 2..A
        logic [1:0] suit;   // 0..3 = C, D, H, S
    } card_t;

    typedef struct packed {
        logic [1:0] count;  // cards to deal this round
        logic [2:0] first;  // first board slot written
    } deal_t;

    // Tallyup and the unused codes 5-7 deal nothing.
    function automatic deal_t deal_lookup(input logic [2:0] r);
        deal_t d;
        d = '0;
        case (r)
            PREFLOP: d = '{count: 2'd2, first: 3'd0};
            FLOP:    d = '{count: 2'd3, first: 3'd2};
            TURN:    d = '{count: 2'd1, first: 3'd5};
            RIVER:   d = '{count: 2'd1, first: 3'd6};
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic card_t idx_to_card(input logic [5:0] idx);
        card_t c;
        c.rank = 4'(idx % 6'(NUM_RANKS));
        c.suit = 2'(idx / 6'(NUM_RANKS));
        return c;
    endfunction

endpackage

// File: rtl/card_dealer_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Shifts right; the feedback bit enters at bit 15.
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset, loads SEED
//   q        out  current LFSR state
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] q
);

    logic [15:0] q_reg;
    logic        feedback;

    assign feedback = q_reg[0] ^ q_reg[2] ^ q_reg[3] ^ q_reg[5];
    assign q        = q_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_reg <= SEED;
        end else begin
            q_reg <= {feedback, q_reg[15:1]};
        end
    end

endmodule

// File: rtl/card_dealer.sv
// card_dealer: on each round-advance pulse, deals the cards of the round just
// entered from a 52-card deck, never repeating a card within one hand.
// Candidates come from an LFSR; after MAX_TRIES misses a linear scan finds the
// lowest free card. Dealt cards are held per board slot for the display.
// Ports:
//   clk         in   system clock
//   reset_n     in   synchronous active-low reset
//   deal_start  in   1-cycle pulse: deal for `round`
//   round       in   round code sampled with deal_start
//   rd_slot     in   display read address (0-1 hole, 2-4 flop, 5 turn, 6 river)
//   rd_rank     out  rank at rd_slot, 4'hF when empty (combinational)
//   rd_suit     out  suit at rd_slot, 0 when empty (combinational)
//   card_valid  out  1-cycle pulse per committed card
//   card_slot   out  slot of the committed card, valid with card_valid
//   busy        out  deal in progress
//   overrun     out  1-cycle pulse: deal_start dropped because busy
module card_dealer
    import poker_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       deal_start,
    input  logic [2:0] round,
    input  logic [2:0] rd_slot,
    output logic [3:0] rd_rank,
    output logic [1:0] rd_suit,
    output logic       card_valid,
    output logic [2:0] card_slot,
    output logic       busy,
    output logic       overrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DRAW = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    localparam logic [1:0] ST_EMIT = 2'd3;

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    logic [15:0]          lfsr_q;
    logic [1:0]           state_reg;
    logic [1:0]           count_reg;
    logic [2:0]           slot_reg;
    logic [5:0]           cand_reg;
    logic [5:0]           scan_reg;
    logic [TRY_W-1:0]     tries_reg;
    logic [DECK_SIZE-1:0] used_reg;
    logic                 overrun_reg;
    card_t                slot_card_reg [NUM_SLOTS];
    logic                 slot_full_reg [NUM_SLOTS];

    deal_t      req;
    logic       accept;
    logic       new_hand;
    logic       emit_we;
    logic [5:0] draw_idx;
    logic       draw_ok;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (lfsr_q)
    );

    assign req      = deal_lookup(round);
    assign accept   = (state_reg == ST_IDLE) && deal_start && (req.count != 2'd0);
    assign new_hand = accept && (round == PREFLOP);
    assign emit_we  = (state_reg == ST_EMIT);
    assign draw_idx = lfsr_q[5:0];
    // The range test guards the bitmap lookup for indices 52..63.
    assign draw_ok  = (draw_idx < 6'(DECK_SIZE)) && !used_reg[draw_idx];

    assign card_valid = emit_we;
    assign card_slot  = emit_we ? slot_reg : 3'd0;
    assign busy       = (state_reg != ST_IDLE);
    assign overrun    = overrun_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            slot_reg    <= '0;
            cand_reg    <= '0;
            scan_reg    <= '0;
            tries_reg   <= '0;
            used_reg    <= '0;
            overrun_reg <= 1'b0;
        end else begin
            // Zero-count requests are no-ops even while busy, so they never overrun.
            overrun_reg <= deal_start && (state_reg != ST_IDLE) && (req.count != 2'd0);
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (new_hand) begin
                            used_reg <= '0;
                        end
                        slot_reg  <= req.first;
                        count_reg <= req.count;
                        tries_reg <= '0;
                        state_reg <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (draw_ok) begin
                        cand_reg  <= draw_idx;
                        state_reg <= ST_EMIT;
                    end else if (tries_reg == TRY_W'(MAX_TRIES - 1)) begin
                        scan_reg  <= '0;
                        state_reg <= ST_SCAN;
                    end else begin
                        tries_reg <= tries_reg + 1'b1;
                    end
                end
                ST_SCAN: begin
                    // At most 7 cards are used, so a free index is always found.
                    if (!used_reg[scan_reg]) begin
                        cand_reg  <= scan_reg;
                        state_reg <= ST_EMIT;
                    end else begin
                        scan_reg <= scan_reg + 1'b1;
                    end
                end
                default: begin // ST_EMIT
                    used_reg[cand_reg] <= 1'b1;
                    count_reg          <= count_reg - 1'b1;
                    slot_reg           <= slot_reg + 1'b1;
                    tries_reg          <= '0;
                    state_reg          <= (count_reg == 2'd1) ? ST_IDLE : ST_DRAW;
                end
            endcase
        end
    end

    // One register pair per board slot; a new hand empties every slot.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (!reset_n || new_hand) begin
                    slot_full_reg[gi] <= 1'b0;
                    slot_card_reg[gi] <= '0;
                end else if (emit_we && (slot_reg == 3'(gi))) begin
                    slot_full_reg[gi] <= 1'b1;
                    slot_card_reg[gi] <= idx_to_card(cand_reg);
                end
            end
        end
    endgenerate

    // Address 7 matches no slot and reads as empty.
    always_comb begin
        rd_rank = 4'hF;
        rd_suit = 2'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if ((rd_slot == 3'(i)) && slot_full_reg[i]) begin
                rd_rank = slot_card_reg[i].rank;
                rd_suit = slot_card_reg[i].suit;
            end
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed bench for card_dealer. A scoreboard queue holds the
// slots each deal_start should produce; a monitor pops them on card_valid.
// A second instance with MAX_TRIES = 1 exercises the linear scan fallback.
module tb_card_dealer;

    logic       clk;
    logic       reset_n;
    logic       deal_start;
    logic       deal_start_s;
    logic [2:0] round;
    logic [2:0] rd_slot;

    logic [3:0] rd_rank,    rd_rank_s;
    logic [1:0] rd_suit,    rd_suit_s;
    logic       card_valid, card_valid_s;
    logic [2:0] card_slot,  card_slot_s;
    logic       busy,       busy_s;
    logic       overrun,    overrun_s;

    int n_assert  = 0;
    int n_fail    = 0;
    int n_cards   = 0;
    int n_over    = 0;
    int n_cards_s = 0;
    int exp_q[$];

    logic [15:0] m_lfsr;

    card_dealer #(.SEED(16'hACE1), .MAX_TRIES(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .deal_start (deal_start),
        .round      (round),
        .rd_slot    (rd_slot),
        .rd_rank    (rd_rank),
        .rd_suit    (rd_suit),
        .card_valid (card_valid),
        .card_slot  (card_slot),
        .busy       (busy),
        .overrun    (overrun)
    );

    card_dealer #(.SEED(16'hACE1), .MAX_TRIES(1)) dut_s (
        .clk        (clk),
        .reset_n    (reset_n),
        .deal_start (deal_start_s),
        .round      (round),
        .rd_slot    (rd_slot),
        .rd_rank    (rd_rank_s),
        .rd_suit    (rd_suit_s),
        .card_valid (card_valid_s),
        .card_slot  (card_slot_s),
        .busy       (busy_s),
        .overrun    (overrun_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    initial begin
        m_lfsr = 16'hACE1;
        forever begin
            @(posedge clk);
            m_lfsr = reset_n ? lfsr_step(m_lfsr) : 16'hACE1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard on card_valid, pulse counters.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (card_valid) begin
                    n_cards++;
                    if (exp_q.size() == 0) begin
                        check("card_slot_unexpected", 32'(card_slot), 32'hFFFF_FFFF);
                    end else begin
                        check("card_slot", 32'(card_slot), exp_q.pop_front());
                    end
                end
                if (overrun) n_over++;
                if (card_valid_s) n_cards_s++;
            end
        end
    end

    task automatic push_round(input logic [2:0] r);
        case (r)
            3'd0: begin exp_q.push_back(0); exp_q.push_back(1); end
            3'd1: begin exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); end
            3'd2: exp_q.push_back(5);
            3'd3: exp_q.push_back(6);
            default: ;
        endcase
    endtask

    // Holds deal_start for `hold` cycles; expectations pushed once.
    task automatic deal(input logic [2:0] r, input int hold);
        @(negedge clk);
        round      = r;
        deal_start = 1'b1;
        push_round(r);
        repeat (hold) @(negedge clk);
        deal_start = 1'b0;
    endtask

    task automatic wait_idle(input bit sel, input string tag);
        for (int k = 0; k < 300; k++) begin
            if (!(sel ? busy_s : busy)) break;
            @(negedge clk);
        end
        check(tag, 32'(sel ? busy_s : busy), 0);
    endtask

    // Deck index from the display port: -1 empty, 99 malformed.
    task automatic read_slot(input int s, output int idx_m, output int idx_s);
        rd_slot = 3'(s);
        #1;
        if (rd_rank == 4'hF)   idx_m = -1;
        else if (rd_rank > 12) idx_m = 99;
        else                   idx_m = int'(rd_rank) + 13 * int'(rd_suit);
        if (rd_rank_s == 4'hF)   idx_s = -1;
        else if (rd_rank_s > 12) idx_s = 99;
        else                     idx_s = int'(rd_rank_s) + 13 * int'(rd_suit_s);
    endtask

    initial begin
        int a, b, xs, base, obase, dups, found;
        int board[7];
        int snap[7];
        logic [15:0] nxt;

        reset_n = 1'b0; deal_start = 1'b0; deal_start_s = 1'b0;
        round = 3'd0; rd_slot = 3'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rd_rank",    32'(rd_rank), 32'hF);
        check("rst_rd_suit",    32'(rd_suit), 0);
        check("rst_card_valid", 32'(card_valid), 0);
        check("rst_card_slot",  32'(card_slot), 0);
        check("rst_busy",       32'(busy), 0);
        check("rst_overrun",    32'(overrun), 0);
        check("rst_s_rd_rank",  32'(rd_rank_s), 32'hF);
        reset_n = 1'b1;
        $display("step reset: done");

        // 1. Preflop
        base = n_cards;
        deal(3'd0, 1);
        wait_idle(0, "t1_idle");
        check("t1_cards", n_cards - base, 2);
        read_slot(0, a, xs);
        read_slot(1, b, xs);
        check("t1_slot0_range", 32'(a >= 0 && a < 52), 1);
        check("t1_slot1_range", 32'(b >= 0 && b < 52), 1);
        check("t1_distinct",    32'(a != b), 1);
        $display("step preflop: slots 0,1 = %0d,%0d", a, b);

        // 2. Rest of the hand
        deal(3'd1, 1); wait_idle(0, "t2_flop_idle");
        deal(3'd2, 1); wait_idle(0, "t2_turn_idle");
        deal(3'd3, 1); wait_idle(0, "t2_river_idle");
        check("t2_cards", n_cards - base, 7);
        dups = 0;
        for (int s = 0; s < 7; s++) begin
            read_slot(s, board[s], xs);
            check($sformatf("t2_slot%0d_range", s), 32'(board[s] >= 0 && board[s] < 52), 1);
            for (int t = 0; t < s; t++) if (board[t] == board[s]) dups++;
        end
        check("t2_duplicates", dups, 0);
        check("t2_sb_empty", exp_q.size(), 0);
        $display("step full hand: %0d %0d %0d %0d %0d %0d %0d",
                 board[0], board[1], board[2], board[3], board[4], board[5], board[6]);

        // 5. Tallyup deals nothing
        base = n_cards; obase = n_over;
        deal(3'd4, 1);
        for (int k = 0; k < 5; k++) begin
            check("t5_busy", 32'(busy), 0);
            @(negedge clk);
        end
        check("t5_cards", n_cards - base, 0);
        check("t5_overrun", n_over - obase, 0);
        for (int s = 0; s < 7; s++) begin
            read_slot(s, snap[s], xs);
            check($sformatf("t5_slot%0d_kept", s), snap[s], board[s]);
        end
        $display("step tallyup: no-op");

        // 4. Second flop start one cycle later is dropped
        deal(3'd0, 1); wait_idle(0, "t4_preflop_idle");
        base = n_cards; obase = n_over;
        deal(3'd1, 2);
        wait_idle(0, "t4_flop_idle");
        check("t4_overrun", n_over - obase, 1);
        check("t4_cards", n_cards - base, 3);
        read_slot(5, a, xs);
        read_slot(6, b, xs);
        check("t4_turn_empty",  a, -1);
        check("t4_river_empty", b, -1);
        $display("step overrun: %0d overrun pulses", n_over - obase);

        // 3. Scan fallback on the MAX_TRIES = 1 instance
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge clk);
            nxt = lfsr_step(m_lfsr);
            if (nxt[5:0] >= 6'd52) found = 1;
        end
        check("t3_miss_found", found, 1);
        base = n_cards_s;
        round = 3'd0;
        deal_start_s = 1'b1;
        @(negedge clk);
        deal_start_s = 1'b0;
        wait_idle(1, "t3_idle");
        check("t3_cards", n_cards_s - base, 2);
        read_slot(0, xs, a);
        read_slot(1, xs, b);
        check("t3_scan_lowest", a, 0);
        check("t3_second_range", 32'(b >= 1 && b < 52), 1);
        $display("step scan: slots 0,1 = %0d,%0d", a, b);

        // 6. Reset mid-flop
        deal(3'd0, 1); wait_idle(0, "t6_preflop_idle");
        deal(3'd1, 1);
        for (int k = 0; k < 100; k++) begin
            if (card_valid) break;
            @(negedge clk);
        end
        check("t6_first_card", 32'(card_valid), 1);
        reset_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        check("t6_busy", 32'(busy), 0);
        check("t6_card_valid", 32'(card_valid), 0);
        for (int s = 0; s < 7; s++) begin
            read_slot(s, a, xs);
            check($sformatf("t6_slot%0d_empty", s), a, -1);
        end
        check("t6_rd_rank", 32'(rd_rank), 32'hF);
        reset_n = 1'b1;
        base = n_cards;
        deal(3'd0, 1); wait_idle(0, "t6_redeal_idle");
        check("t6_redeal_cards", n_cards - base, 2);
        read_slot(0, a, xs);
        read_slot(1, b, xs);
        check("t6_redeal_range", 32'(a >= 0 && a < 52 && b >= 0 && b < 52), 1);
        check("t6_redeal_distinct", 32'(a != b), 1);
        check("final_sb_empty", exp_q.size(), 0);
        $display("step reset mid-flop: redeal %0d,%0d", a, b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
